// File: rtl/song_sequencer.sv
// song_sequencer: steps through the sheet lookup one index at a time, holds
// each note for its programmed number of duration units and drives a square
// wave on the speaker pin. Start/stop come from game-event control.
module song_sequencer #(
   parameter int unsigned UNIT_CYCLES = 3_125_000, // clk cycles per duration unit, >= 2
   parameter int unsigned SONG_LEN    = 33         // sheet entries played, 1..1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        loop_en,
   output logic [9:0]  number,
   input  logic [19:0] note,
   input  logic [4:0]  duration,
   output logic        speaker,
   output logic        busy,
   output logic        done
);

   localparam int unsigned UW        = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
   localparam logic [9:0]    LAST_IDX  = 10'(SONG_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PLAY = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [9:0]      number_q, number_d;
   logic [19:0]     note_q, note_d;
   logic [4:0]      dur_q, dur_d;
   logic [UW-1:0]   unit_cnt_q, unit_cnt_d;
   logic [4:0]      units_done_q, units_done_d;
   logic [18:0]     tone_cnt_q, tone_cnt_d;
   logic            speaker_q, speaker_d;

   logic            unit_wrap;
   logic            note_end;
   logic            last_idx;
   logic            is_tone;
   logic [18:0]     half;
   logic [18:0]     tone_last;

   // Per-note timing and tone decode shared by the FSM and the datapath.
   assign unit_wrap = (state_q == PLAY) && (unit_cnt_q == UNIT_LAST);
   assign note_end  = unit_wrap && ((units_done_q + 5'd1) == dur_q);
   assign last_idx  = (number_q == LAST_IDX);
   assign is_tone   = (note_q > 20'd1);
   assign half      = note_q[19:1];
   assign tone_last = half - 19'd1;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking (<=) so every register updates
      // from pre-edge values; blocking (=) would create order-dependent races.
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; stop overrides everything, including start.
   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven,
      // so no latch is inferred for a branch that forgets the signal.
      state_d = state_q;
      if (stop) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: state_d = PLAY;
            PLAY: if (note_end) state_d = (last_idx && !loop_en) ? DONE : LOAD;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Status outputs decoded straight from the state register.
   always_comb begin
      busy = (state_q == LOAD) || (state_q == PLAY);
      done = (state_q == DONE);
   end

   // Datapath next values: sheet latch, unit/tone counters, index and speaker.
   always_comb begin
      number_d     = number_q;
      note_d       = note_q;
      dur_d        = dur_q;
      unit_cnt_d   = unit_cnt_q;
      units_done_d = units_done_q;
      tone_cnt_d   = tone_cnt_q;

      unique case (state_q)
         IDLE: number_d = 10'd0;
         LOAD: begin
            note_d       = note;
            dur_d        = (duration == 5'd0) ? 5'd1 : duration;
            unit_cnt_d   = '0;
            units_done_d = 5'd0;
            tone_cnt_d   = 19'd0;
         end
         PLAY: begin
            if (unit_wrap) begin
               unit_cnt_d   = '0;
               units_done_d = units_done_q + 5'd1;
            end else begin
               unit_cnt_d   = unit_cnt_q + UW'(1);
            end
            if (!is_tone)                    tone_cnt_d = 19'd0;
            else if (tone_cnt_q == tone_last) tone_cnt_d = 19'd0;
            else                             tone_cnt_d = tone_cnt_q + 19'd1;
            // Wrapping back to index 0 covers both the loop and the finish case.
            if (note_end) number_d = last_idx ? 10'd0 : number_q + 10'd1;
         end
         DONE: number_d = 10'd0;
         default: number_d = 10'd0;
      endcase

      if (stop) number_d = 10'd0;

      // Speaker only runs while staying in PLAY; any exit forces it low.
      if ((state_q == PLAY) && (state_d == PLAY) && is_tone && (tone_cnt_q == tone_last))
         speaker_d = ~speaker_q;
      else if ((state_q == PLAY) && (state_d == PLAY))
         speaker_d = speaker_q;
      else
         speaker_d = 1'b0;
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         number_q     <= 10'd0;
         note_q       <= 20'd0;
         dur_q        <= 5'd0;
         unit_cnt_q   <= '0;
         units_done_q <= 5'd0;
         tone_cnt_q   <= 19'd0;
         speaker_q    <= 1'b0;
      end else begin
         number_q     <= number_d;
         note_q       <= note_d;
         dur_q        <= dur_d;
         unit_cnt_q   <= unit_cnt_d;
         units_done_q <= units_done_d;
         tone_cnt_q   <= tone_cnt_d;
         speaker_q    <= speaker_d;
      end
   end

   assign number  = number_q;
   assign speaker = speaker_q;

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed scenarios for song_sequencer with a three-entry
// sheet (idx0 note=8 dur=2, idx1 rest dur=1, idx2 note=4 dur=0).
module tb_song_sequencer;

   localparam int unsigned UNIT = 4;
   localparam int unsigned LEN  = 3;

   logic        clk = 1'b0;
   logic        reset, start, stop, loop_en;
   logic [9:0]  number;
   logic [19:0] note;
   logic [4:0]  duration;
   logic        speaker, busy, done;

   int n_cmp = 0;
   int n_err = 0;

   // Per-cycle expectations for one song, cycle 0 = LOAD of idx0.
   int exp_num [19] = '{0,0,0,0,0,0,0,0,0, 1,1,1,1,1, 2,2,2,2,2};
   bit exp_spk [19] = '{0,0,0,0,0,1,1,1,1, 0,0,0,0,0, 0,0,0,1,1};

   song_sequencer #(.UNIT_CYCLES(UNIT), .SONG_LEN(LEN)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
      .loop_en  (loop_en),
      .number   (number),
      .note     (note),
      .duration (duration),
      .speaker  (speaker),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Sheet model.
   always_comb begin
      note = 20'd0;
      duration = 5'd0;
      case (number)
         10'd0: begin note = 20'd8; duration = 5'd2; end
         10'd1: begin note = 20'd1; duration = 5'd1; end
         10'd2: begin note = 20'd4; duration = 5'd0; end
         default: begin note = 20'd0; duration = 5'd0; end
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one cycle; returns with cycle 0 (LOAD idx0) observable.
   task automatic start_song(input bit lp);
      loop_en = lp;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_cmp++; if (number !== 10'd0) begin n_err++; $display("FAIL reset_number got %0d want 0", number); end
      n_cmp++; if (speaker !== 1'b0) begin n_err++; $display("FAIL reset_speaker got %b want 0", speaker); end
      n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done got %b want 0", done); end
      reset = 1'b0;
      step();
      n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_idle_busy got %b want 0", busy); end
   endtask

   // One non-looping song, cycles 0..20; optionally pulses start while busy/done.
   task automatic test_single_song(input bit extra_starts, input string tag);
      int  en;
      bit  es, eb, ed;
      start_song(1'b0);
      for (int k = 0; k <= 20; k++) begin
         if (k > 0) step();
         if (k < 19) begin en = exp_num[k]; es = exp_spk[k]; eb = 1'b1; ed = 1'b0; end
         else        begin en = 0; es = 1'b0; eb = 1'b0; ed = (k == 19); end
         n_cmp++; if (number !== 10'(en)) begin n_err++; $display("FAIL %s_number[%0d] got %0d want %0d", tag, k, number, en); end
         n_cmp++; if (speaker !== es)     begin n_err++; $display("FAIL %s_speaker[%0d] got %b want %b", tag, k, speaker, es); end
         n_cmp++; if (busy !== eb)        begin n_err++; $display("FAIL %s_busy[%0d] got %b want %b", tag, k, busy, eb); end
         n_cmp++; if (done !== ed)        begin n_err++; $display("FAIL %s_done[%0d] got %b want %b", tag, k, done, ed); end
         start = extra_starts && (k == 3 || k == 12 || k == 19);
      end
      start = 1'b0;
   endtask

   // Looping playback across more than two passes, then stop.
   task automatic test_loop();
      int en;
      bit es;
      start_song(1'b1);
      for (int k = 0; k <= 44; k++) begin
         if (k > 0) step();
         en = exp_num[k % 19];
         es = exp_spk[k % 19];
         n_cmp++; if (number !== 10'(en)) begin n_err++; $display("FAIL loop_number[%0d] got %0d want %0d", k, number, en); end
         n_cmp++; if (speaker !== es)     begin n_err++; $display("FAIL loop_speaker[%0d] got %b want %b", k, speaker, es); end
         n_cmp++; if (busy !== 1'b1)      begin n_err++; $display("FAIL loop_busy[%0d] got %b want 1", k, busy); end
         n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL loop_done[%0d] got %b want 0", k, done); end
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      loop_en = 1'b0;
      n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL loop_stop_busy got %b want 0", busy); end
      n_cmp++; if (number !== 10'd0)   begin n_err++; $display("FAIL loop_stop_number got %0d want 0", number); end
   endtask

   task automatic test_stop();
      // Stop during the idx1 rest.
      start_song(1'b0);
      for (int k = 0; k < 11; k++) step();
      n_cmp++; if (number !== 10'd1) begin n_err++; $display("FAIL stop_pre_number got %0d want 1", number); end
      stop = 1'b1;
      step();
      stop = 1'b0;
      n_cmp++; if (number !== 10'd0)  begin n_err++; $display("FAIL stop_number got %0d want 0", number); end
      n_cmp++; if (speaker !== 1'b0)  begin n_err++; $display("FAIL stop_speaker got %b want 0", speaker); end
      n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL stop_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)     begin n_err++; $display("FAIL stop_done got %b want 0", done); end
      for (int k = 0; k < 25; k++) begin
         step();
         n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL stop_after[%0d] got busy=%b done=%b want 0/0", k, busy, done);
         end
      end
      // Stop while the speaker is high during idx0.
      start_song(1'b0);
      for (int k = 0; k < 6; k++) step();
      n_cmp++; if (speaker !== 1'b1) begin n_err++; $display("FAIL stop2_pre_speaker got %b want 1", speaker); end
      stop = 1'b1;
      step();
      stop = 1'b0;
      n_cmp++; if (speaker !== 1'b0)  begin n_err++; $display("FAIL stop2_speaker got %b want 0", speaker); end
      n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL stop2_busy got %b want 0", busy); end
      // Start together with stop in IDLE.
      start = 1'b1;
      stop = 1'b1;
      step();
      start = 1'b0;
      stop = 1'b0;
      n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL startstop_busy got %b want 0", busy); end
      step();
      n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL startstop_busy2 got %b want 0", busy); end
      n_cmp++; if (number !== 10'd0)  begin n_err++; $display("FAIL startstop_number got %0d want 0", number); end
   endtask

   task automatic test_reset_mid();
      start_song(1'b0);
      for (int k = 0; k < 17; k++) step();
      n_cmp++; if (number !== 10'd2)  begin n_err++; $display("FAIL rstmid_pre_number got %0d want 2", number); end
      n_cmp++; if (speaker !== 1'b1)  begin n_err++; $display("FAIL rstmid_pre_speaker got %b want 1", speaker); end
      reset = 1'b1;
      step();
      n_cmp++; if (number !== 10'd0)  begin n_err++; $display("FAIL rstmid_number got %0d want 0", number); end
      n_cmp++; if (speaker !== 1'b0)  begin n_err++; $display("FAIL rstmid_speaker got %b want 0", speaker); end
      n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)     begin n_err++; $display("FAIL rstmid_done got %b want 0", done); end
      reset = 1'b0;
      step();
      n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rstmid_idle_busy got %b want 0", busy); end
      test_single_song(1'b0, "replay");
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      loop_en = 1'b0;
      test_reset();
      test_single_song(1'b0, "song");
      test_loop();
      test_stop();
      test_single_song(1'b1, "busy_start");
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
